seq_1101_gen: RTL and testbench

//  Serial pattern transmitter. It emits bursts of the 4-bit frame 1101 (MSB first), separated by programmable zero gaps.
//  It drives the serial input of the team's 1101 sequence detectors, both on silicon self-test paths and in benches.
//  A valid/ready handshake supports backpressure. Frames in a burst, bit positions and gaps are all counted in RTL.

---
 rtl/seq_1101_gen_if.sv | 27 ++
 rtl/seq_1101_gen.sv | 146 ++++++++++++++
 tb/tb_seq_1101_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_1101_gen_if.sv
// Handshake/control bundle between the 1101 frame generator and its controller/sink.
interface seq_1101_gen_if #(
    parameter int GAP_W = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] n_frames;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             dout_ready;
    logic             dout;
    logic             dout_valid;
    logic             sop;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frames_sent;

    modport master (
        input  start, n_frames, gap, abort, dout_ready,
        output dout, dout_valid, sop, busy, done, frames_sent
    );

    modport slave (
        output start, n_frames, gap, abort, dout_ready,
        input  dout, dout_valid, sop, busy, done, frames_sent
    );
endinterface

// File: rtl/seq_1101_gen.sv
// Serial 1101 burst generator with zero gaps and valid/ready backpressure.
// Define SEQ_OVERLAP_EN to drop the leading bit of back-to-back frames (gap==0), giving 1101101...
module seq_1101_gen #(
    parameter int               PAT_W = 4,
    parameter logic [PAT_W-1:0] PAT   = 4'b1101,
    parameter int               GAP_W = 4,
    parameter int               CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    seq_1101_gen_if.master  bus
);
    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
`ifdef SEQ_OVERLAP_EN
    localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PAT_W - 2);
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {ST_IDLE, ST_PAT, ST_GAP, ST_FIN} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [GAP_W-1:0] gcnt_reg, gcnt_next;
    logic [GAP_W-1:0] gap_lat_reg, gap_lat_next;
    logic [CNT_W-1:0] nfr_reg, nfr_next;
    logic [CNT_W-1:0] sent_reg, sent_next;
    logic             sof_reg, sof_next;
    logic             dout_reg, dout_next;
    logic             valid_reg, valid_next;
    logic             sop_reg, sop_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             xfer, last_frame, streaming;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            gcnt_reg    <= '0;
            gap_lat_reg <= '0;
            nfr_reg     <= '0;
            sent_reg    <= '0;
            sof_reg     <= 1'b0;
            dout_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            sop_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            gcnt_reg    <= gcnt_next;
            gap_lat_reg <= gap_lat_next;
            nfr_reg     <= nfr_next;
            sent_reg    <= sent_next;
            sof_reg     <= sof_next;
            dout_reg    <= dout_next;
            valid_reg   <= valid_next;
            sop_reg     <= sop_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        gcnt_next    = gcnt_reg;
        gap_lat_next = gap_lat_reg;
        nfr_next     = nfr_reg;
        sent_next    = sent_reg;
        sof_next     = sof_reg;
        xfer         = valid_reg && bus.dout_ready;
        last_frame   = ({1'b0, sent_reg} + (CNT_W+1)'(1)) == {1'b0, nfr_reg};

        if (bus.abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        nfr_next     = bus.n_frames;
                        gap_lat_next = bus.gap;
                        sent_next    = '0;
                        idx_next     = IDX_TOP;
                        sof_next     = 1'b1;
                        state_next   = (bus.n_frames == '0) ? ST_FIN : ST_PAT;
                    end
                end
                ST_PAT: begin
                    if (xfer) begin
                        sof_next = 1'b0;
                        if (idx_reg == '0) begin
                            if (sent_reg != CNT_MAX)
                                sent_next = sent_reg + CNT_W'(1);
                            if (last_frame) begin
                                state_next = ST_FIN;
                            end else if (gap_lat_reg == '0) begin
`ifdef SEQ_OVERLAP_EN
                                idx_next = IDX_OVL;
`else
                                idx_next = IDX_TOP;
`endif
                                sof_next = 1'b1;
                            end else begin
                                state_next = ST_GAP;
                                gcnt_next  = gap_lat_reg;
                            end
                        end else begin
                            idx_next = idx_reg - IDX_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (xfer) begin
                        if (gcnt_reg == GAP_W'(1)) begin
                            state_next = ST_PAT;
                            idx_next   = IDX_TOP;
                            sof_next   = 1'b1;
                        end else begin
                            gcnt_next = gcnt_reg - GAP_W'(1);
                        end
                    end
                end
                ST_FIN:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end

        // Outputs decode the position the FSM holds after this edge; valid waits one cycle after launch.
        streaming  = (state_next == ST_PAT) || (state_next == ST_GAP);
        valid_next = streaming && ((state_reg == ST_PAT) || (state_reg == ST_GAP));
        dout_next  = valid_next && (state_next == ST_PAT) && PAT[idx_next];
        sop_next   = valid_next && (state_next == ST_PAT) && sof_next;
        busy_next  = streaming;
        done_next  = (state_next == ST_FIN);
    end

    assign bus.dout        = dout_reg;
    assign bus.dout_valid  = valid_reg;
    assign bus.sop         = sop_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.frames_sent = sent_reg;
endmodule

// File: tb/tb_seq_1101_gen.sv
// Directed bench for seq_1101_gen: vector table for plain bursts, hand sequences for handshake corners.
module tb_seq_1101_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    seq_1101_gen_if #(.GAP_W(4), .CNT_W(8)) bus ();

    seq_1101_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, ab, rdy;
        logic [7:0] nf;
        logic [3:0] gp;
        logic       e_d, e_v, e_sop, e_busy, e_done;
        logic [7:0] e_fs;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic ab, logic rdy, logic [7:0] nf, logic [3:0] gp,
                                logic d, logic v, logic s, logic b, logic dn, logic [7:0] fs);
        vec_t r;
        r.st = st; r.ab = ab; r.rdy = rdy; r.nf = nf; r.gp = gp;
        r.e_d = d; r.e_v = v; r.e_sop = s; r.e_busy = b; r.e_done = dn; r.e_fs = fs;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] outs();
        return {bus.dout, bus.dout_valid, bus.sop, bus.busy, bus.done, bus.frames_sent};
    endfunction

    logic [31:0] got;
    int          got_len;
    int          hits;
    logic        held_pend, held_d, held_s, seen;
    logic [3:0]  win;

    initial begin
        bus.start = 0; bus.abort = 0; bus.dout_ready = 1; bus.n_frames = 0; bus.gap = 0;

        // Reset state
        step(); step();
        chk("reset_outs", 32'(outs()), 32'h0);
        rst = 1'b1;
        step();

        // T2: single frame
        tbl.push_back(mk(1,0,1,8'd1,4'd0, 0,0,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd1,4'd0, 1,1,1,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd1,4'd0, 1,1,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd1,4'd0, 0,1,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd1,4'd0, 1,1,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd1,4'd0, 0,0,0,0,1,8'd1));
        tbl.push_back(mk(0,0,1,8'd1,4'd0, 0,0,0,0,0,8'd1));
        // T3: two frames, gap 3
        tbl.push_back(mk(1,0,1,8'd2,4'd3, 0,0,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 1,1,1,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 1,1,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 0,1,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 1,1,0,1,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 0,1,0,1,0,8'd1));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 0,1,0,1,0,8'd1));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 0,1,0,1,0,8'd1));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 1,1,1,1,0,8'd1));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 1,1,0,1,0,8'd1));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 0,1,0,1,0,8'd1));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 1,1,0,1,0,8'd1));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 0,0,0,0,1,8'd2));
        tbl.push_back(mk(0,0,1,8'd2,4'd3, 0,0,0,0,0,8'd2));
        // T6: empty burst, then start+abort together
        tbl.push_back(mk(1,0,1,8'd0,4'd0, 0,0,0,0,1,8'd0));
        tbl.push_back(mk(0,0,1,8'd0,4'd0, 0,0,0,0,0,8'd0));
        tbl.push_back(mk(1,1,1,8'd5,4'd0, 0,0,0,0,0,8'd0));
        tbl.push_back(mk(0,0,1,8'd5,4'd0, 0,0,0,0,0,8'd0));

        foreach (tbl[i]) begin
            bus.start = tbl[i].st; bus.abort = tbl[i].ab; bus.dout_ready = tbl[i].rdy;
            bus.n_frames = tbl[i].nf; bus.gap = tbl[i].gp;
            step();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({tbl[i].e_d, tbl[i].e_v, tbl[i].e_sop, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_fs}));
        end
        bus.start = 0; bus.abort = 0;

        // T4: three frames, gap 0, ready toggling
        bus.n_frames = 8'd3; bus.gap = 4'd0; bus.dout_ready = 0; bus.start = 1;
        step();
        bus.start = 0;
        got = '0; got_len = 0; held_pend = 0; seen = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (held_pend) begin
                chk("t4_hold", {29'd0, bus.dout_valid, bus.dout, bus.sop}, {29'd0, 1'b1, held_d, held_s});
                held_pend = 0;
            end
            if (bus.done) begin seen = 1; break; end
            bus.dout_ready = cyc[0];
            if (bus.dout_valid && bus.dout_ready) begin
                got = {got[30:0], bus.dout};
                got_len++;
            end else if (bus.dout_valid) begin
                held_pend = 1; held_d = bus.dout; held_s = bus.sop;
            end
            step();
        end
        chk("t4_done_seen", 32'(seen), 32'd1);
        chk("t4_frames", 32'(bus.frames_sent), 32'd3);
`ifdef SEQ_OVERLAP_EN
        chk("t4_len", 32'(got_len), 32'd10);
        chk("t4_stream", got, 32'b1101101101);
`else
        chk("t4_len", 32'(got_len), 32'd12);
        chk("t4_stream", got, 32'b110111011101);
`endif
        hits = 0;
        for (int i = 0; i + 4 <= got_len && i < 29; i++) begin
            win = got[i +: 4];
            if (win == 4'b1101) hits++;
        end
        chk("t4_detect", 32'(hits), 32'd3);
        bus.dout_ready = 1;
        step();

        // T5: abort on frame 2 bit 1, with an ignored start earlier in the burst
        bus.n_frames = 8'd4; bus.gap = 4'd0; bus.start = 1;
        step();
        bus.start = 0; seen = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (bus.dout_valid && bus.frames_sent == 8'd1 && bus.dout == 1'b0) begin seen = 1; break; end
            bus.start = (cyc == 2);
            step();
        end
        bus.start = 0;
        chk("t5_reached", 32'(seen), 32'd1);
        bus.abort = 1;
        step();
        bus.abort = 0;
        chk("t5_abort_outs", 32'(outs()), 32'd1);
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.done || bus.busy || bus.dout_valid) hits++;
        end
        chk("t5_stays_idle", 32'(hits), 32'd0);

        // Long burst: 255 frames reaches the top of the counter
        bus.n_frames = 8'd255; bus.gap = 4'd0; bus.start = 1;
        step();
        bus.start = 0; seen = 0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (bus.done) begin seen = 1; break; end
            step();
        end
        chk("sat_done_seen", 32'(seen), 32'd1);
        chk("sat_frames", 32'(bus.frames_sent), 32'd255);
        step();

        // T1: asynchronous reset mid-burst
        bus.n_frames = 8'd5; bus.gap = 4'd2; bus.start = 1;
        step();
        bus.start = 0;
        for (int i = 0; i < 6; i++) step();
        chk("t1_busy_before", 32'(bus.busy), 32'd1);
        #2 rst = 1'b0;
        #1 chk("t1_async_outs", 32'(outs()), 32'h0);
        step();
        rst = 1'b1;
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.done || bus.busy || bus.dout_valid) hits++;
        end
        chk("t1_no_done", 32'(hits), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
